cpu_phase_sequencer: RTL and testbench

- Multi-cycle phase controller for the RV32I-subset core.
- Steps every instruction through FETCH/DECODE/EXEC/MEM/WB and drives the enables the control unit cannot time itself: IR load, PC write, register-file write, and the IMEM/DMEM request handshakes.
- Replaces delay-based writeback timing with explicit, clocked register-file write timing.
- Sits between the instruction/data memories and the datapath. Combinational mux selects (ALUop, BSel, PCSel, …) stay in the control unit.

---
 rtl/cpu_phase_sequencer_pkg.sv | 25 ++
 rtl/cpu_phase_sequencer_if.sv | 29 ++
 rtl/cpu_phase_sequencer_opcode_class_dec.sv | 13 +
 rtl/cpu_phase_sequencer.sv | 97 +++++++++
 tb/tb_cpu_phase_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cpu_phase_sequencer_pkg.sv
// cpu_seq_pkg: state and instruction-class encodings shared by the phase sequencer and hazard logic
package cpu_seq_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   typedef enum logic [2:0] {
      CLS_LOAD,
      CLS_STORE,
      CLS_OP,
      CLS_OPIMM,
      CLS_BRANCH,
      CLS_ILLEGAL
   } cls_t;
endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// cpu_phase_sequencer_if: memory handshakes, phase enables and status between sequencer and core
interface cpu_phase_sequencer_if;
   logic        run;
   logic [6:0]  opcode;
   logic        imem_ack;
   logic        dmem_ack;
   logic        imem_req;
   logic        ir_load;
   logic        dmem_req;
   logic        dmem_we;
   logic        rf_we;
   logic        pc_we;
   logic        retire;
   logic [2:0]  state;
   logic        illegal;
   logic        timeout_err;
   logic [31:0] cycle_count;
   logic [31:0] retire_count;
   modport master (
      output run, opcode, imem_ack, dmem_ack,
      input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, retire,
             state, illegal, timeout_err, cycle_count, retire_count
   );
   modport slave (
      input  run, opcode, imem_ack, dmem_ack,
      output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, retire,
             state, illegal, timeout_err, cycle_count, retire_count
   );
endinterface

// File: rtl/cpu_phase_sequencer_opcode_class_dec.sv
// opcode_class_dec: pure combinational map from RV32I opcode to instruction class
module opcode_class_dec
   import cpu_seq_pkg::*;
(
   input  logic [6:0] opcode,
   output cls_t       cls
);
   assign cls = opcode == OPC_LOAD   ? CLS_LOAD   :
                opcode == OPC_STORE  ? CLS_STORE  :
                opcode == OPC_OP     ? CLS_OP     :
                opcode == OPC_OPIMM  ? CLS_OPIMM  :
                opcode == OPC_BRANCH ? CLS_BRANCH : CLS_ILLEGAL;
endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: FETCH/DECODE/EXEC/MEM/WB phase controller with memory-ack timeout trap.
// Optional performance counters enabled by defining CPU_SEQ_PERF_COUNTERS_EN.
module cpu_phase_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                  clk,
   input logic                  rst,
   cpu_phase_sequencer_if.slave bus
);
   state_t     state_q, state_d, done_st;
   cls_t       cls_q, cls_d;
   logic [7:0] wait_q;
   logic       illegal_q, timeout_q, at_limit, starved;
   logic       imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we;

   opcode_class_dec u_dec (.opcode(bus.opcode), .cls(cls_d));

   assign at_limit = wait_q == 8'(TIMEOUT_CYCLES - 1);
   // a pending request with no ack this cycle; ack on the limit cycle still wins
   assign starved  = (state_q == FETCH && !bus.imem_ack) || (state_q == MEM && !bus.dmem_ack);
   assign done_st  = bus.run ? FETCH : IDLE;

   always_ff @(posedge clk)
      state_q <= rst ? IDLE : state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cls_q     <= CLS_LOAD;
         wait_q    <= 8'd0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cls_q     <= state_q == DECODE ? cls_d : cls_q;
         wait_q    <= (state_d == state_q && (state_q == FETCH || state_q == MEM)) ? wait_q + 8'd1 : 8'd0;
         illegal_q <= illegal_q | (state_q == DECODE && cls_d == CLS_ILLEGAL);
         timeout_q <= timeout_q | (starved && at_limit);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = bus.run ? FETCH : IDLE;
         FETCH:   state_d = bus.imem_ack ? DECODE : at_limit ? TRAP : FETCH;
         DECODE:  state_d = cls_d == CLS_ILLEGAL ? TRAP : EXEC;
         EXEC:    state_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? MEM :
                            (cls_q == CLS_OP || cls_q == CLS_OPIMM)   ? WB  :
                            cls_q == CLS_BRANCH ? done_st : IDLE;
         MEM:     state_d = bus.dmem_ack ? (cls_q == CLS_STORE ? done_st : WB) :
                            at_limit ? TRAP : MEM;
         WB:      state_d = done_st;
         TRAP:    state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req = state_q == FETCH;
      ir_load  = state_q == FETCH && bus.imem_ack;
      dmem_req = state_q == MEM;
      dmem_we  = state_q == MEM && cls_q == CLS_STORE;
      rf_we    = state_q == WB;
      pc_we    = state_q == WB || (state_q == EXEC && cls_q == CLS_BRANCH) ||
                 (state_q == MEM && bus.dmem_ack && cls_q == CLS_STORE);
   end

   assign bus.imem_req    = imem_req;
   assign bus.ir_load     = ir_load;
   assign bus.dmem_req    = dmem_req;
   assign bus.dmem_we     = dmem_we;
   assign bus.rf_we       = rf_we;
   assign bus.pc_we       = pc_we;
   assign bus.retire      = pc_we;
   assign bus.state       = state_q;
   assign bus.illegal     = illegal_q;
   assign bus.timeout_err = timeout_q;

`ifdef CPU_SEQ_PERF_COUNTERS_EN
   logic [31:0] cyc_q, ret_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= 32'd0;
         ret_q <= 32'd0;
      end else begin
         cyc_q <= cyc_q + {31'd0, state_q != IDLE && state_q != TRAP};
         ret_q <= ret_q + {31'd0, pc_we};
      end
   end
   assign bus.cycle_count  = cyc_q;
   assign bus.retire_count = ret_q;
`else
   assign bus.cycle_count  = 32'd0;
   assign bus.retire_count = 32'd0;
`endif
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: directed phase-sequence checks with a per-cycle expected-output scoreboard
module tb_cpu_phase_sequencer;
   import cpu_seq_pkg::*;
   localparam logic [6:0] E_NONE = 7'b0000000;
   localparam logic [6:0] E_WAIT = 7'b1000000;
   localparam logic [6:0] E_FET  = 7'b1100000;
   localparam logic [6:0] E_MEMR = 7'b0010000;
   localparam logic [6:0] E_MEMW = 7'b0011000;
   localparam logic [6:0] E_ST   = 7'b0011011;
   localparam logic [6:0] E_BR   = 7'b0000011;
   localparam logic [6:0] E_WB   = 7'b0000111;
   localparam logic [6:0] OPX    = 7'b1111111;
`ifdef CPU_SEQ_PERF_COUNTERS_EN
   localparam logic [31:0] EXP_CYC = 32'd12;
   localparam logic [31:0] EXP_RET = 32'd3;
`else
   localparam logic [31:0] EXP_CYC = 32'd0;
   localparam logic [31:0] EXP_RET = 32'd0;
`endif

   typedef struct {
      string       tag;
      logic [11:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic exp_ill = 1'b0;
   logic exp_to = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   exp_t sb[$];

   cpu_phase_sequencer_if bus ();
   cpu_phase_sequencer #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic reset_seq();
      rst = 1'b1;
      bus.run = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_ill = 1'b0;
      exp_to = 1'b0;
   endtask

   task automatic cyc(input logic r, input logic [6:0] op, input logic ia, input logic da,
                      input logic [2:0] es, input logic [6:0] en, input string tag);
      exp_t e;
      exp_t got;
      logic [11:0] obs;
      bus.run = r;
      bus.opcode = op;
      bus.imem_ack = ia;
      bus.dmem_ack = da;
      e.tag = tag;
      e.v = {es, en, exp_ill, exp_to};
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      obs = {bus.state, bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.rf_we,
             bus.pc_we, bus.retire, bus.illegal, bus.timeout_err};
      n_assert++;
      assert (obs === got.v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", got.tag, obs, got.v);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.run = 1'b0;
      bus.opcode = 7'd0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      reset_seq();
      cyc(0, OPC_OP, 0, 0, IDLE, E_NONE, "reset_idle");
      // OP zero-wait
      cyc(1, OPC_OP, 0, 0, IDLE, E_NONE, "op_idle");
      cyc(1, OPC_OP, 1, 0, FETCH, E_FET, "op_fetch");
      cyc(1, OPC_OP, 0, 0, DECODE, E_NONE, "op_decode");
      cyc(1, OPC_OP, 0, 0, EXEC, E_NONE, "op_exec");
      cyc(1, OPC_OP, 0, 0, WB, E_WB, "op_wb");
      // LOAD with three MEM cycles
      cyc(1, OPC_LOAD, 1, 0, FETCH, E_FET, "ld_fetch");
      cyc(1, OPC_LOAD, 0, 0, DECODE, E_NONE, "ld_decode");
      cyc(1, OPC_LOAD, 0, 0, EXEC, E_NONE, "ld_exec");
      cyc(1, OPC_LOAD, 0, 0, MEM, E_MEMR, "ld_mem1");
      cyc(1, OPC_LOAD, 0, 0, MEM, E_MEMR, "ld_mem2");
      cyc(1, OPC_LOAD, 0, 1, MEM, E_MEMR, "ld_mem3");
      cyc(1, OPC_LOAD, 0, 0, WB, E_WB, "ld_wb");
      // STORE
      cyc(1, OPC_STORE, 1, 0, FETCH, E_FET, "st_fetch");
      cyc(1, OPC_STORE, 0, 0, DECODE, E_NONE, "st_decode");
      cyc(1, OPC_STORE, 0, 0, EXEC, E_NONE, "st_exec");
      cyc(1, OPC_STORE, 0, 0, MEM, E_MEMW, "st_mem_wait");
      cyc(1, OPC_STORE, 0, 1, MEM, E_ST, "st_mem_ack");
      // BRANCH
      cyc(1, OPC_BRANCH, 1, 0, FETCH, E_FET, "br_fetch");
      cyc(1, OPC_BRANCH, 0, 0, DECODE, E_NONE, "br_decode");
      cyc(1, OPC_BRANCH, 0, 1, EXEC, E_BR, "br_exec");
      // OPIMM with run dropped in EXEC
      cyc(1, OPC_OPIMM, 1, 0, FETCH, E_FET, "oi_fetch");
      cyc(1, OPC_OPIMM, 0, 0, DECODE, E_NONE, "oi_decode");
      cyc(0, OPC_OPIMM, 0, 0, EXEC, E_NONE, "oi_exec_rundrop");
      cyc(0, OPC_OPIMM, 0, 0, WB, E_WB, "oi_wb");
      cyc(0, OPC_OPIMM, 1, 1, IDLE, E_NONE, "idle_ack_ignored");
      cyc(0, OPC_OPIMM, 0, 0, IDLE, E_NONE, "idle_stays");
      // reset in the middle of MEM
      cyc(1, OPC_LOAD, 0, 0, IDLE, E_NONE, "rm_idle");
      cyc(1, OPC_LOAD, 1, 0, FETCH, E_FET, "rm_fetch");
      cyc(1, OPC_LOAD, 0, 0, DECODE, E_NONE, "rm_decode");
      cyc(1, OPC_LOAD, 0, 0, EXEC, E_NONE, "rm_exec");
      cyc(1, OPC_LOAD, 0, 0, MEM, E_MEMR, "rm_mem");
      rst = 1'b1;
      bus.run = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(0, OPC_LOAD, 0, 1, IDLE, E_NONE, "rm_after_rst");
      // illegal opcode
      cyc(1, OPX, 0, 0, IDLE, E_NONE, "il_idle");
      cyc(1, OPX, 1, 0, FETCH, E_FET, "il_fetch");
      cyc(1, OPX, 0, 0, DECODE, E_NONE, "il_decode");
      exp_ill = 1'b1;
      for (int i = 0; i < 20; i++) cyc(1, OPC_OP, 1, 1, TRAP, E_NONE, "il_trap_sticky");
      reset_seq();
      cyc(0, OPC_OP, 0, 0, IDLE, E_NONE, "il_reset_clear");
      // timeout with ack withheld
      cyc(1, OPC_OP, 0, 0, IDLE, E_NONE, "to_idle");
      for (int i = 0; i < 16; i++) cyc(1, OPC_OP, 0, 0, FETCH, E_WAIT, "to_wait");
      exp_to = 1'b1;
      cyc(1, OPC_OP, 1, 1, TRAP, E_NONE, "to_trap");
      // ack on the limit cycle wins
      reset_seq();
      cyc(1, OPC_OP, 0, 0, IDLE, E_NONE, "tb_idle");
      for (int i = 0; i < 15; i++) cyc(1, OPC_OP, 0, 0, FETCH, E_WAIT, "tb_wait");
      cyc(1, OPC_OP, 1, 0, FETCH, E_FET, "tb_ack_at_limit");
      cyc(1, OPC_OP, 0, 0, DECODE, E_NONE, "tb_decode");
      // three OPs for the performance counters
      reset_seq();
      cyc(1, OPC_OP, 0, 0, IDLE, E_NONE, "pc_idle");
      for (int k = 0; k < 3; k++) begin
         cyc(1, OPC_OP, 1, 0, FETCH, E_FET, "pc_fetch");
         cyc(1, OPC_OP, 0, 0, DECODE, E_NONE, "pc_decode");
         cyc(k < 2, OPC_OP, 0, 0, EXEC, E_NONE, "pc_exec");
         cyc(k < 2, OPC_OP, 0, 0, WB, E_WB, "pc_wb");
      end
      cyc(0, OPC_OP, 0, 0, IDLE, E_NONE, "pc_end_idle");
      n_assert++;
      assert (bus.cycle_count === EXP_CYC)
      else begin
         n_fail++;
         $error("FAIL cycle_count: observed %0d expected %0d", bus.cycle_count, EXP_CYC);
      end
      n_assert++;
      assert (bus.retire_count === EXP_RET)
      else begin
         n_fail++;
         $error("FAIL retire_count: observed %0d expected %0d", bus.retire_count, EXP_RET);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
